// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
//
// Oversampling front end of the UART receiver. It runs two counters:
// edge_cnt counts oversample ticks within a bit, and bit_cnt counts bits
// within a frame. Around each bit centre it takes three samples of the line
// and registers their majority as sampled_bit, with a one-cycle
// sample_valid strobe. frame_done pulses once after the last tick of the
// last bit.
//
// Parameters
//   PRESCALE_W : width of prescale and edge_cnt
//   BIT_CNT_W  : width of frame_len and bit_cnt
//
// Ports
//   CLK          in   oversampling clock
//   RST          in   asynchronous active-high reset
//   RX_IN        in   serial line, idles high
//   cnt_en       in   counter enable from the RX FSM; low clears both counters
//   dat_samp_en  in   sampling enable from the RX FSM
//   prescale     in   oversampling ratio (8, 16 or 32; anything else -> 8)
//   frame_len    in   bits per frame including start/stop (0 or 1 -> 1)
//   edge_cnt     out  oversample index within the current bit
//   bit_cnt      out  bit index within the frame, 0 = start bit
//   sampled_bit  out  majority-voted bit value
//   sample_valid out  one-cycle pulse when sampled_bit updates
//   frame_done   out  one-cycle pulse after the last bit's final tick
//
// Build option
//   UART_RX_SYNC_EN : when defined, RX_IN passes through a two-flop
//   synchronizer (reset to idle-high) before the sample registers. The
//   capture points in edge_cnt terms are unchanged, so the line-to-sample
//   delay grows by two cycles. When undefined, RX_IN must already be
//   synchronous to CLK.
// ---------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  cnt_en,
    input  logic                  dat_samp_en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BIT_CNT_W-1:0]  frame_len,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  frame_done
);

    localparam logic [PRESCALE_W-1:0] PS_8   = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] PS_16  = PRESCALE_W'(16);
    localparam logic [PRESCALE_W-1:0] PS_32  = PRESCALE_W'(32);
    localparam logic [PRESCALE_W-1:0] E_ONE  = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] E_TWO  = PRESCALE_W'(2);
    localparam logic [BIT_CNT_W-1:0]  B_ONE  = BIT_CNT_W'(1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  sampled_bit_q, sampled_bit_d;
    logic                  sample_valid_q, sample_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic [PRESCALE_W-1:0] ps_q, ps_d;       // latched prescale (P)
    logic                  cnt_en_q;         // cnt_en one cycle ago

    // -----------------------------------------------------------------------
    // Derived frame/bit geometry
    // -----------------------------------------------------------------------
    logic [PRESCALE_W-1:0] ps_legal;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] vote_pt;
    logic [BIT_CNT_W-1:0]  bit_last_idx;
    logic                  edge_last;
    logic                  bit_last;
    logic                  cnt_start;

    always_comb begin
        ps_legal = PS_8;
        if (prescale == PS_16 || prescale == PS_32) begin
            ps_legal = prescale;
        end
    end

    assign half      = ps_q >> 1;
    assign vote_pt   = half + E_TWO;
    assign edge_last = (edge_cnt_q == ps_q - E_ONE);

    // frame_len 0 and 1 both mean a single-bit frame.
    assign bit_last_idx = (frame_len <= B_ONE) ? '0 : frame_len - B_ONE;

    // '>=' rather than '==' so a frame_len shrunk mid-frame still wraps
    // at the next bit boundary instead of running on to counter overflow.
    assign bit_last = (bit_cnt_q >= bit_last_idx);

    // The prescale is captured on the first enabled cycle. edge_cnt is 0 on
    // that cycle, so the compares below using the previous ps_q cannot hit.
    assign cnt_start = cnt_en && !cnt_en_q;
    assign ps_d      = cnt_start ? ps_legal : ps_q;

    // -----------------------------------------------------------------------
    // Line input (optionally synchronized)
    // -----------------------------------------------------------------------
    logic rx_line;

`ifdef UART_RX_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= RX_IN;
            sync2_q <= sync1_q;
        end
    end

    assign rx_line = sync2_q;
`else
    assign rx_line = RX_IN;
`endif

    // -----------------------------------------------------------------------
    // Three sample registers at edge_cnt = H-1, H, H+1.
    // Captures run whenever the counters run; dat_samp_en only gates the
    // vote, so a disabled bit simply leaves stale samples that get
    // overwritten on the next bit.
    // -----------------------------------------------------------------------
    logic [2:0] samp;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_samp
            logic                  cap_q;
            logic [PRESCALE_W-1:0] cap_pt;

            assign cap_pt = half - E_ONE + PRESCALE_W'(gi);

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    cap_q <= 1'b1;
                end else if (cnt_en && (edge_cnt_q == cap_pt)) begin
                    cap_q <= rx_line;
                end
            end

            assign samp[gi] = cap_q;
        end
    endgenerate

    logic vote;
    assign vote = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

    // -----------------------------------------------------------------------
    // Counter / strobe next-state
    // -----------------------------------------------------------------------
    always_comb begin
        edge_cnt_d     = edge_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        sampled_bit_d  = sampled_bit_q;
        sample_valid_d = 1'b0;
        frame_done_d   = 1'b0;

        if (!cnt_en) begin
            // Abort: counters clear, no pulses; sampled_bit keeps its value.
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else begin
            if (edge_last) begin
                edge_cnt_d = '0;
                if (bit_last) begin
                    bit_cnt_d    = '0;
                    frame_done_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + B_ONE;
                end
            end else begin
                edge_cnt_d = edge_cnt_q + E_ONE;
            end

            // The vote point H+2 is always below P-1, so a vote never lands
            // on the same tick as frame_done.
            if (dat_samp_en && (edge_cnt_q == vote_pt)) begin
                sampled_bit_d  = vote;
                sample_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            sampled_bit_q  <= 1'b1;
            sample_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            ps_q           <= PS_8;
            cnt_en_q       <= 1'b0;
        end else begin
            edge_cnt_q     <= edge_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            sampled_bit_q  <= sampled_bit_d;
            sample_valid_q <= sample_valid_d;
            frame_done_q   <= frame_done_d;
            ps_q           <= ps_d;
            cnt_en_q       <= cnt_en;
        end
    end

    assign edge_cnt     = edge_cnt_q;
    assign bit_cnt      = bit_cnt_q;
    assign sampled_bit  = sampled_bit_q;
    assign sample_valid = sample_valid_q;
    assign frame_done   = frame_done_q;

endmodule
